// File: rtl/pkg_rv32_types.sv
// Shared RV32 core types and constants.
// Holds the fetch FSM state type, instruction exception causes and the canonical NOP.
package pkg_rv32_types;

  localparam int unsigned XLEN = 32;

  localparam logic [3:0]  EXC_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0]  EXC_INSTR_ACCESS     = 4'd1;

  // addi x0, x0, 0
  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    StBoot,
    StReq,
    StWait,
    StValid,
    StFault
  } fetch_state_e;

endpackage

// File: rtl/rv32_next_pc.sv
// Combinational next-PC select for a retiring instruction.
// Priority is JALR, then JAL/taken branch, then sequential; flags non-word-aligned targets.
module rv32_next_pc
  import pkg_rv32_types::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic            branch_taken_i,
  input  logic            jal_en_i,
  input  logic            jalr_en_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] jalr_sum;

  assign jalr_sum = rs1_data_i + imm_i;

  always_comb begin
    next_pc_o = pc_i + XLEN'(4);
    if (jalr_en_i) begin
      next_pc_o = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (jal_en_i || branch_taken_i) begin
      next_pc_o = pc_i + imm_i;
    end
  end

  // No compressed instructions, so any target not on a 4-byte boundary faults.
  assign misaligned_o = |next_pc_o[1:0];

endmodule

// File: rtl/rv32_fetch_unit.sv
// Instruction fetch / PC stage: one outstanding req/gnt/rvalid fetch, valid/ready hand-off
// to decode, next-PC selection on retire and a sticky fetch-fault state.
module rv32_fetch_unit
  import pkg_rv32_types::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_err,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            branch_taken,
  input  logic            jal_en,
  input  logic            jalr_en,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  output logic            fault,
  output logic [3:0]      fault_cause,
  output logic [XLEN-1:0] fault_tval
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [3:0]      cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;
  logic            retire;

  rv32_next_pc u_next_pc (
    .pc_i           (pc_q),
    .imm_i          (imm),
    .rs1_data_i     (rs1_data),
    .branch_taken_i (branch_taken),
    .jal_en_i       (jal_en),
    .jalr_en_i      (jalr_en),
    .next_pc_o      (next_pc),
    .misaligned_o   (misaligned)
  );

  assign retire = (state_q == StValid) && instr_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cause_d = cause_q;
    tval_d  = tval_q;
    unique case (state_q)
      StBoot: state_d = StReq;
      // rvalid is deliberately ignored here: it can only be a stale response from before reset.
      StReq: begin
        if (imem_gnt) state_d = StWait;
      end
      StWait: begin
        if (imem_rvalid) begin
          if (imem_err) begin
            state_d = StFault;
            cause_d = EXC_INSTR_ACCESS;
            tval_d  = pc_q;
          end else begin
            state_d = StValid;
            instr_d = imem_rdata;
          end
        end
      end
      StValid: begin
        if (retire) begin
          if (misaligned) begin
            state_d = StFault;
            cause_d = EXC_INSTR_MISALIGNED;
            tval_d  = next_pc;
          end else begin
            state_d = StReq;
            pc_d    = next_pc;
          end
        end
      end
      StFault: state_d = StFault;
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      instr_q <= RV32_NOP;
      cause_q <= EXC_INSTR_MISALIGNED;
      tval_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cause_q <= cause_d;
      tval_q  <= tval_d;
    end
  end

  assign imem_req    = (state_q == StReq);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == StValid);
  assign instr       = instr_q;
  assign instr_pc    = pc_q;
  assign pc_plus4    = pc_q + XLEN'(4);
  assign fault       = (state_q == StFault);
  assign fault_cause = cause_q;
  assign fault_tval  = tval_q;

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Self-checking bench for rv32_fetch_unit: directed scenarios plus randomized fetch/retire
// traffic checked against a behavioural PC model.
module tb_rv32_fetch_unit;
  import pkg_rv32_types::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        branch_taken;
  logic        jal_en;
  logic        jalr_en;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        fault;
  logic [3:0]  fault_cause;
  logic [31:0] fault_tval;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] model_pc;
  bit          faulted;

  rv32_fetch_unit #(
    .RESET_PC (RST_PC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .imem_err     (imem_err),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .pc_plus4     (pc_plus4),
    .branch_taken (branch_taken),
    .jal_en       (jal_en),
    .jalr_en      (jalr_en),
    .imm          (imm),
    .rs1_data     (rs1_data),
    .fault        (fault),
    .fault_cause  (fault_cause),
    .fault_tval   (fault_tval)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // {misaligned, target}: target computed straight from the retire rules.
  function automatic logic [32:0] ref_next(input logic [31:0] pc, input bit br, input bit jal,
                                           input bit jalr, input logic [31:0] im,
                                           input logic [31:0] rs1);
    logic [31:0] t;
    if (jalr) t = ((rs1 + im) / 2) * 2;
    else if (jal || br) t = pc + im;
    else t = pc + 4;
    return {(t % 4) != 0, t};
  endfunction

  task automatic idle();
    imem_gnt     = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = '0;
    imem_err     = 1'b0;
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    jal_en       = 1'b0;
    jalr_en      = 1'b0;
    imm          = '0;
    rs1_data     = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, RV32_NOP);
    check("rst_instr_pc", instr_pc, RST_PC);
    check("rst_pc_plus4", pc_plus4, RST_PC + 4);
    check("rst_fault", fault, 0);
    check("rst_cause", fault_cause, 0);
    check("rst_tval", fault_tval, 0);
    rst_n    = 1'b1;
    model_pc = RST_PC;
    faulted  = 1'b0;
    @(negedge clk);
    check("boot_one_cycle", imem_req, 1);
  endtask

  task automatic do_fetch(input logic [31:0] word, input int gnt_dly, input int rv_dly,
                          input bit err);
    int n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", imem_req, 1);
    check("req_addr", imem_addr, model_pc);
    for (int i = 0; i < gnt_dly; i++) begin
      imem_rvalid = rb();
      @(negedge clk);
      check("req_hold", imem_req, 1);
      check("addr_hold", imem_addr, model_pc);
    end
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    check("wait_no_req", imem_req, 0);
    for (int i = 0; i < rv_dly; i++) begin
      @(negedge clk);
      check("wait_no_req", imem_req, 0);
      check("wait_not_valid", instr_valid, 0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    imem_err    = err;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_err    = 1'b0;
    imem_rdata  = $urandom;
    if (err) begin
      check("acc_fault", fault, 1);
      check("acc_cause", fault_cause, 1);
      check("acc_tval", fault_tval, model_pc);
      check("acc_no_valid", instr_valid, 0);
      faulted = 1'b1;
    end else begin
      check("valid_rise", instr_valid, 1);
    end
  endtask

  task automatic do_retire(input logic [31:0] word, input int rdy_dly, input bit br,
                           input bit jal, input bit jalr, input logic [31:0] im,
                           input logic [31:0] rs1);
    logic [32:0] nx;
    check("valid", instr_valid, 1);
    check("instr", instr, word);
    check("instr_pc", instr_pc, model_pc);
    check("pc_plus4", pc_plus4, model_pc + 4);
    for (int i = 0; i < rdy_dly; i++) begin
      instr_ready  = 1'b0;
      branch_taken = rb();
      jal_en       = rb();
      jalr_en      = rb();
      imm          = $urandom;
      rs1_data     = $urandom;
      @(negedge clk);
      check("stall_valid", instr_valid, 1);
      check("stall_instr", instr, word);
      check("stall_addr", imem_addr, model_pc);
      check("stall_no_req", imem_req, 0);
    end
    instr_ready  = 1'b1;
    branch_taken = br;
    jal_en       = jal;
    jalr_en      = jalr;
    imm          = im;
    rs1_data     = rs1;
    @(negedge clk);
    instr_ready  = 1'b0;
    branch_taken = rb();
    jal_en       = rb();
    jalr_en      = rb();
    nx = ref_next(model_pc, br, jal, jalr, im, rs1);
    if (nx[32]) begin
      check("mis_fault", fault, 1);
      check("mis_cause", fault_cause, 0);
      check("mis_tval", fault_tval, nx[31:0]);
      check("mis_no_req", imem_req, 0);
      check("mis_pc_kept", imem_addr, model_pc);
      faulted = 1'b1;
    end else begin
      model_pc = nx[31:0];
      check("next_req", imem_req, 1);
      check("next_addr", imem_addr, model_pc);
      check("next_no_fault", fault, 0);
      check("next_not_valid", instr_valid, 0);
    end
  endtask

  task automatic fault_hold(input int n, input logic [3:0] cause, input logic [31:0] tval);
    for (int i = 0; i < n; i++) begin
      imem_gnt    = rb();
      imem_rvalid = rb();
      imem_err    = rb();
      instr_ready = rb();
      @(negedge clk);
      check("hold_fault", fault, 1);
      check("hold_cause", fault_cause, cause);
      check("hold_tval", fault_tval, tval);
      check("hold_no_req", imem_req, 0);
      check("hold_no_valid", instr_valid, 0);
    end
    idle();
  endtask

  int          vc[3];
  logic [31:0] w;
  logic [31:0] im;
  logic [31:0] rs1;
  int          sel;

  initial begin
    do_reset();

    // Zero-wait memory, sequential NOPs: one instruction every three cycles.
    for (int k = 0; k < 3; k++) begin
      do_fetch(RV32_NOP, 0, 0, 1'b0);
      vc[k] = cyc;
      do_retire(RV32_NOP, 0, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
    end
    check("tput_0_1", 32'(vc[1] - vc[0]), 3);
    check("tput_1_2", 32'(vc[2] - vc[1]), 3);

    // PC is 0xC: JAL to 0x100, taken branch -8, back, not-taken branch.
    w = $urandom; do_fetch(w, 0, 0, 1'b0); do_retire(w, 0, 1'b0, 1'b1, 1'b0, 32'hF4, $urandom);
    w = $urandom; do_fetch(w, 0, 0, 1'b0);
    do_retire(w, 0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, $urandom);
    check("br_taken_target", model_pc, 32'hF8);
    w = $urandom; do_fetch(w, 0, 0, 1'b0); do_retire(w, 0, 1'b0, 1'b1, 1'b0, 32'h8, $urandom);
    w = $urandom; do_fetch(w, 0, 0, 1'b0);
    do_retire(w, 0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, $urandom);
    check("br_not_taken_target", model_pc, 32'h104);

    // Delayed grant and stalled decode, then JAL to 0x40 and JAL +0x10.
    w = $urandom; do_fetch(w, 3, 1, 1'b0);
    do_retire(w, 4, 1'b0, 1'b1, 1'b0, 32'h40 - 32'h104, $urandom);
    w = $urandom; do_fetch(w, 0, 0, 1'b0); do_retire(w, 0, 1'b0, 1'b1, 1'b0, 32'h10, $urandom);
    check("jal_target", model_pc, 32'h50);

    // JALR beats branch; odd sum clears bit 0 to reach 0xFFFF_FFFC, then wrap to 0.
    w = $urandom; do_fetch(w, 0, 0, 1'b0);
    do_retire(w, 0, 1'b1, 1'b0, 1'b1, 32'hD, 32'hFFFF_FFF0);
    w = $urandom; do_fetch(w, 0, 0, 1'b0); do_retire(w, 0, 1'b0, 1'b0, 1'b0, $urandom, '0);
    check("wrap_target", model_pc, 32'h0);

    // Access fault at 0x80, sticky until reset.
    w = $urandom; do_fetch(w, 0, 0, 1'b0); do_retire(w, 0, 1'b0, 1'b1, 1'b0, 32'h80, '0);
    do_fetch($urandom, 1, 1, 1'b1);
    fault_hold(5, 4'd1, 32'h80);
    do_reset();

    // JALR to 0x2002 is misaligned: fault with tval = target, no request.
    w = $urandom; do_fetch(w, 0, 0, 1'b0);
    do_retire(w, 0, 1'b0, 1'b1, 1'b1, 32'h2, 32'h2001);
    fault_hold(5, 4'd0, 32'h2002);
    do_reset();

    // Async reset while waiting at 0x200; the late response must be dropped.
    w = $urandom; do_fetch(w, 0, 0, 1'b0); do_retire(w, 0, 1'b0, 1'b1, 1'b0, 32'h200, '0);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", imem_req, 0);
    check("arst_addr", imem_addr, RST_PC);
    check("arst_valid", instr_valid, 0);
    @(negedge clk);
    rst_n       = 1'b1;
    model_pc    = RST_PC;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("late_rvalid_req", imem_req, 1);
      check("late_rvalid_valid", instr_valid, 0);
    end
    imem_rvalid = 1'b0;
    w = $urandom; do_fetch(w, 0, 0, 1'b0); do_retire(w, 0, 1'b0, 1'b0, 1'b0, '0, '0);

    // Randomized traffic against the PC model.
    for (int k = 0; k < 40; k++) begin
      w = $urandom;
      do_fetch(w, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 15) == 0);
      if (!faulted) begin
        sel = $urandom_range(0, 3);
        im  = ($urandom_range(0, 63) << 2) - 32'd128;
        if ($urandom_range(0, 7) == 0) im = im + 32'd2;
        rs1 = $urandom & 32'hFFFF_FFFD;
        do_retire(w, $urandom_range(0, 2), (sel == 1) || (sel >= 2 && rb()),
                  (sel == 2) || (sel == 3 && rb()), sel == 3, im, rs1);
      end
      if (faulted) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
